mem_arbiter: RTL and testbench

- Shares the single main-memory port between the instruction-cache and data-cache refill/writeback paths.
- Accepts one cache-line transaction at a time from either requester and forwards it to memory over a valid/ready handshake.
- Waits for the memory response, which covers the MEM_REQ_DELAY/MEM_RESP_DELAY latency, and returns the line to the owning requester.
- Sits between the two caches and the memory model, at the top level of the core.

---
 rtl/brisc_pkg.sv | 21 ++
 rtl/mem_arb_picker.sv | 44 ++++
 rtl/mem_arbiter.sv | 165 ++++++++++++++++
 tb/tb_mem_arbiter.sv | 400 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/brisc_pkg.sv
// Shared core types and constants for the brisc memory subsystem.
package brisc_pkg;

    localparam int unsigned ADDRESS_BITS     = 32;
    localparam int unsigned CACHE_LINE_LEN   = 128;
    localparam int unsigned BYTE_LEN         = 8;
    localparam int unsigned LINE_OFFSET_BITS = $clog2(CACHE_LINE_LEN / BYTE_LEN);

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_ISSUE = 2'd1,
        ARB_WAIT  = 2'd2,
        ARB_RESP  = 2'd3
    } arb_state_e;

    typedef enum logic {
        REQ_IC = 1'b0,
        REQ_DC = 1'b1
    } requester_e;

endpackage

// File: rtl/mem_arb_picker.sv
// Combinational 2-way picker between icache and dcache requests.
// MEM_ARBITER_RR_EN selects round-robin; otherwise the dcache has fixed priority.
module mem_arb_picker
    import brisc_pkg::*;
(
    input  logic       ic_valid,
    input  logic       dc_valid,
    input  requester_e last_grant,
    output logic       grant_ic,
    output logic       grant_dc,
    output requester_e winner
);

`ifdef MEM_ARBITER_RR_EN
    always_comb begin
        winner = REQ_DC;
        if (ic_valid && dc_valid) begin
            // Under contention, favour whoever was not served last.
            if (last_grant == REQ_DC) begin
                winner = REQ_IC;
            end else begin
                winner = REQ_DC;
            end
        end else if (ic_valid) begin
            winner = REQ_IC;
        end
        grant_ic = ic_valid && (winner == REQ_IC);
        grant_dc = dc_valid && (winner == REQ_DC);
    end
`else
    logic unused_last_grant;
    assign unused_last_grant = last_grant;

    always_comb begin
        winner = REQ_DC;
        if (ic_valid && !dc_valid) begin
            winner = REQ_IC;
        end
        grant_ic = ic_valid && (winner == REQ_IC);
        grant_dc = dc_valid && (winner == REQ_DC);
    end
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Shares the main-memory port between icache and dcache, one line transaction at a time.
// Optional MEM_ARBITER_RR_EN switches contention handling to round-robin.
module mem_arbiter
    import brisc_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDRESS_BITS,
    parameter int unsigned LINE_W = CACHE_LINE_LEN,
    parameter int unsigned OFF_W  = LINE_OFFSET_BITS
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              ic_req_valid,
    input  logic [ADDR_W-1:0] ic_req_addr,
    output logic              ic_req_ready,
    output logic              ic_resp_valid,
    output logic [LINE_W-1:0] ic_resp_rdata,

    input  logic              dc_req_valid,
    input  logic              dc_req_store,
    input  logic [ADDR_W-1:0] dc_req_addr,
    input  logic [LINE_W-1:0] dc_req_wdata,
    output logic              dc_req_ready,
    output logic              dc_resp_valid,
    output logic [LINE_W-1:0] dc_resp_rdata,

    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic              mem_req_store,
    output logic [ADDR_W-1:0] mem_req_addr,
    output logic [LINE_W-1:0] mem_req_wdata,
    input  logic              mem_resp_valid,
    input  logic [LINE_W-1:0] mem_resp_rdata,

    output logic              busy
);

    arb_state_e        state_q, state_d;
    requester_e        owner_q, owner_d;
    logic              store_q, store_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [LINE_W-1:0] wdata_q, wdata_d;
    logic [LINE_W-1:0] ic_rdata_q, ic_rdata_d;
    logic [LINE_W-1:0] dc_rdata_q, dc_rdata_d;

    logic       grant_ic, grant_dc;
    requester_e winner;
    requester_e last_grant;

`ifdef MEM_ARBITER_RR_EN
    requester_e last_grant_q;
    logic       accept;

    assign accept     = (state_q == ARB_IDLE) && (grant_ic || grant_dc);
    assign last_grant = last_grant_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant_q <= REQ_DC;
        end else if (accept) begin
            last_grant_q <= winner;
        end
    end
`else
    assign last_grant = REQ_DC;
`endif

    mem_arb_picker u_picker (
        .ic_valid   (ic_req_valid),
        .dc_valid   (dc_req_valid),
        .last_grant (last_grant),
        .grant_ic   (grant_ic),
        .grant_dc   (grant_dc),
        .winner     (winner)
    );

    always_comb begin
        state_d       = state_q;
        owner_d       = owner_q;
        store_d       = store_q;
        addr_d        = addr_q;
        wdata_d       = wdata_q;
        ic_rdata_d    = ic_rdata_q;
        dc_rdata_d    = dc_rdata_q;
        ic_req_ready  = 1'b0;
        dc_req_ready  = 1'b0;
        ic_resp_valid = 1'b0;
        dc_resp_valid = 1'b0;
        mem_req_valid = 1'b0;

        unique case (state_q)
            ARB_IDLE: begin
                ic_req_ready = grant_ic;
                dc_req_ready = grant_dc;
                if (grant_ic || grant_dc) begin
                    owner_d = winner;
                    state_d = ARB_ISSUE;
                    if (winner == REQ_DC) begin
                        store_d = dc_req_store;
                        addr_d  = dc_req_addr;
                        wdata_d = dc_req_wdata;
                    end else begin
                        store_d = 1'b0;
                        addr_d  = ic_req_addr;
                        wdata_d = '0;
                    end
                end
            end
            ARB_ISSUE: begin
                mem_req_valid = 1'b1;
                if (mem_req_ready) begin
                    state_d = ARB_WAIT;
                end
            end
            ARB_WAIT: begin
                // Only the owner's line register captures, so the other side's data is kept.
                if (mem_resp_valid) begin
                    if (owner_q == REQ_IC) begin
                        ic_rdata_d = mem_resp_rdata;
                    end else begin
                        dc_rdata_d = mem_resp_rdata;
                    end
                    state_d = ARB_RESP;
                end
            end
            ARB_RESP: begin
                ic_resp_valid = (owner_q == REQ_IC);
                dc_resp_valid = (owner_q == REQ_DC);
                state_d       = ARB_IDLE;
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ARB_IDLE;
            owner_q    <= REQ_DC;
            store_q    <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            ic_rdata_q <= '0;
            dc_rdata_q <= '0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            store_q    <= store_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            ic_rdata_q <= ic_rdata_d;
            dc_rdata_q <= dc_rdata_d;
        end
    end

    logic unused_addr_off;
    assign unused_addr_off = ^addr_q[OFF_W-1:0];

    assign mem_req_store = store_q;
    assign mem_req_addr  = {addr_q[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
    assign mem_req_wdata = wdata_q;
    assign ic_resp_rdata = ic_rdata_q;
    assign dc_resp_rdata = dc_rdata_q;
    assign busy          = (state_q != ARB_IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter; each task drives one scenario.
module tb_mem_arbiter;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned LINE_W = 128;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              ic_req_valid = 1'b0;
    logic [ADDR_W-1:0] ic_req_addr = '0;
    logic              ic_req_ready;
    logic              ic_resp_valid;
    logic [LINE_W-1:0] ic_resp_rdata;
    logic              dc_req_valid = 1'b0;
    logic              dc_req_store = 1'b0;
    logic [ADDR_W-1:0] dc_req_addr = '0;
    logic [LINE_W-1:0] dc_req_wdata = '0;
    logic              dc_req_ready;
    logic              dc_resp_valid;
    logic [LINE_W-1:0] dc_resp_rdata;
    logic              mem_req_valid;
    logic              mem_req_ready = 1'b0;
    logic              mem_req_store;
    logic [ADDR_W-1:0] mem_req_addr;
    logic [LINE_W-1:0] mem_req_wdata;
    logic              mem_resp_valid = 1'b0;
    logic [LINE_W-1:0] mem_resp_rdata = '0;
    logic              busy;

    int tests = 0;
    int fails = 0;

    localparam logic [LINE_W-1:0] LINE_A = 128'hDEADBEEF0;
    localparam logic [LINE_W-1:0] LINE_B = 128'hCAFE_0000_1234_5678_9ABC_DEF0_0F0F_A5A5;
    localparam logic [LINE_W-1:0] WD_1   = {16{8'h11}};

    always #5 clk = ~clk;

    mem_arbiter dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .ic_req_valid   (ic_req_valid),
        .ic_req_addr    (ic_req_addr),
        .ic_req_ready   (ic_req_ready),
        .ic_resp_valid  (ic_resp_valid),
        .ic_resp_rdata  (ic_resp_rdata),
        .dc_req_valid   (dc_req_valid),
        .dc_req_store   (dc_req_store),
        .dc_req_addr    (dc_req_addr),
        .dc_req_wdata   (dc_req_wdata),
        .dc_req_ready   (dc_req_ready),
        .dc_resp_valid  (dc_resp_valid),
        .dc_resp_rdata  (dc_resp_rdata),
        .mem_req_valid  (mem_req_valid),
        .mem_req_ready  (mem_req_ready),
        .mem_req_store  (mem_req_store),
        .mem_req_addr   (mem_req_addr),
        .mem_req_wdata  (mem_req_wdata),
        .mem_resp_valid (mem_resp_valid),
        .mem_resp_rdata (mem_resp_rdata),
        .busy           (busy)
    );

    // Inputs change 1 time unit after the rising edge; outputs are checked 1 unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #2;
        tests++;
        if ({busy, mem_req_valid, ic_req_ready, dc_req_ready, ic_resp_valid, dc_resp_valid}
            !== 6'b0) begin
            fails++;
            $display("FAIL reset_ctrl: got %b want 000000", {busy, mem_req_valid,
                     ic_req_ready, dc_req_ready, ic_resp_valid, dc_resp_valid});
        end
        tests++;
        if ({ic_resp_rdata, dc_resp_rdata, mem_req_wdata} !== '0 || mem_req_addr !== '0) begin
            fails++;
            $display("FAIL reset_data: got ic=%h dc=%h wd=%h addr=%h want all 0",
                     ic_resp_rdata, dc_resp_rdata, mem_req_wdata, mem_req_addr);
        end
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_ic_read();
        // Cycle T: request presented and accepted.
        ic_req_valid = 1'b1;
        ic_req_addr  = 32'h0000_1004;
        mem_req_ready = 1'b1;
        #1;
        tests++;
        if (ic_req_ready !== 1'b1 || dc_req_ready !== 1'b0) begin
            fails++;
            $display("FAIL ic_accept: got ic_rdy=%b dc_rdy=%b want 1 0", ic_req_ready, dc_req_ready);
        end
        tick();
        ic_req_valid = 1'b0;
        // T+1: issue
        tests++;
        if (mem_req_valid !== 1'b1 || mem_req_addr !== 32'h0000_1000 || mem_req_store !== 1'b0
            || busy !== 1'b1) begin
            fails++;
            $display("FAIL ic_issue: got v=%b addr=%h st=%b busy=%b want 1 00001000 0 1",
                     mem_req_valid, mem_req_addr, mem_req_store, busy);
        end
        tick();
        // T+2: wait, response arrives
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b1;
        mem_resp_rdata = LINE_A;
        tests++;
        if (ic_resp_valid !== 1'b0 || mem_req_valid !== 1'b0) begin
            fails++;
            $display("FAIL ic_wait: got resp_v=%b mem_v=%b want 0 0", ic_resp_valid, mem_req_valid);
        end
        tick();
        mem_resp_valid = 1'b0;
        mem_resp_rdata = '0;
        // T+3: response pulse
        tests++;
        if (ic_resp_valid !== 1'b1 || ic_resp_rdata !== LINE_A || dc_resp_valid !== 1'b0) begin
            fails++;
            $display("FAIL ic_resp: got v=%b data=%h dc_v=%b want 1 %h 0",
                     ic_resp_valid, ic_resp_rdata, dc_resp_valid, LINE_A);
        end
        tick();
        // T+4: idle, pulse over
        tests++;
        if (ic_resp_valid !== 1'b0 || busy !== 1'b0 || dc_resp_valid !== 1'b0) begin
            fails++;
            $display("FAIL ic_done: got v=%b busy=%b dc_v=%b want 0 0 0",
                     ic_resp_valid, busy, dc_resp_valid);
        end
    endtask

    task automatic test_dc_store_stall();
        dc_req_valid = 1'b1;
        dc_req_store = 1'b1;
        dc_req_addr  = 32'h0000_2010;
        dc_req_wdata = WD_1;
        mem_req_ready = 1'b0;
        #1;
        tests++;
        if (dc_req_ready !== 1'b1) begin
            fails++;
            $display("FAIL dc_accept: got %b want 1", dc_req_ready);
        end
        tick();
        dc_req_valid = 1'b0;
        dc_req_store = 1'b0;
        dc_req_wdata = '0;
        for (int i = 0; i < 5; i++) begin
            tests++;
            if (mem_req_valid !== 1'b1 || mem_req_store !== 1'b1 || mem_req_addr !== 32'h2010
                || mem_req_wdata !== WD_1 || dc_req_ready !== 1'b0) begin
                fails++;
                $display("FAIL dc_stall[%0d]: got v=%b st=%b addr=%h wd=%h rdy=%b", i,
                         mem_req_valid, mem_req_store, mem_req_addr, mem_req_wdata, dc_req_ready);
            end
            tick();
        end
        mem_req_ready = 1'b1;
        tick();
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b1;
        mem_resp_rdata = LINE_B;
        tick();
        mem_resp_valid = 1'b0;
        tests++;
        if (dc_resp_valid !== 1'b1 || dc_resp_rdata !== LINE_B || ic_resp_valid !== 1'b0
            || ic_resp_rdata !== LINE_A) begin
            fails++;
            $display("FAIL dc_ack: got v=%b data=%h ic_v=%b ic_data=%h",
                     dc_resp_valid, dc_resp_rdata, ic_resp_valid, ic_resp_rdata);
        end
        tick();
        tests++;
        if (dc_resp_valid !== 1'b0 || busy !== 1'b0) begin
            fails++;
            $display("FAIL dc_ack_once: got v=%b busy=%b want 0 0", dc_resp_valid, busy);
        end
    endtask

    // Completes a transaction already in ARB_ISSUE with zero memory stall; ends in ARB_IDLE.
    task automatic finish_txn(input logic [LINE_W-1:0] line);
        mem_req_ready = 1'b1;
        tick();
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b1;
        mem_resp_rdata = line;
        tick();
        mem_resp_valid = 1'b0;
        tick();
    endtask

`ifdef MEM_ARBITER_RR_EN
    task automatic test_round_robin();
        logic exp_ic [4];
        exp_ic[0] = 1'b1; exp_ic[1] = 1'b0; exp_ic[2] = 1'b1; exp_ic[3] = 1'b0;
        ic_req_valid = 1'b1;
        ic_req_addr  = 32'h0000_3000;
        dc_req_valid = 1'b1;
        dc_req_store = 1'b0;
        dc_req_addr  = 32'h0000_4000;
        #1;
        for (int i = 0; i < 4; i++) begin
            tests++;
            if (ic_req_ready !== exp_ic[i] || dc_req_ready !== !exp_ic[i]) begin
                fails++;
                $display("FAIL rr_grant[%0d]: got ic=%b dc=%b want ic=%b", i,
                         ic_req_ready, dc_req_ready, exp_ic[i]);
            end
            tick();
            finish_txn(LINE_B);
            #1;
        end
        ic_req_valid = 1'b0;
        dc_req_valid = 1'b0;
    endtask
`else
    task automatic test_fixed_priority();
        ic_req_valid = 1'b1;
        ic_req_addr  = 32'h0000_3000;
        dc_req_valid = 1'b1;
        dc_req_store = 1'b0;
        dc_req_addr  = 32'h0000_4004;
        #1;
        tests++;
        if (dc_req_ready !== 1'b1 || ic_req_ready !== 1'b0) begin
            fails++;
            $display("FAIL prio_first: got dc=%b ic=%b want 1 0", dc_req_ready, ic_req_ready);
        end
        tick();
        dc_req_valid = 1'b0;
        tests++;
        if (mem_req_addr !== 32'h0000_4000 || ic_req_ready !== 1'b0) begin
            fails++;
            $display("FAIL prio_issue: got addr=%h ic_rdy=%b want 00004000 0",
                     mem_req_addr, ic_req_ready);
        end
        mem_req_ready = 1'b1;
        tick();
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b1;
        mem_resp_rdata = LINE_A;
        tests++;
        if (ic_req_ready !== 1'b0) begin
            fails++;
            $display("FAIL prio_wait: got ic_rdy=%b want 0", ic_req_ready);
        end
        tick();
        mem_resp_valid = 1'b0;
        tests++;
        if (ic_req_ready !== 1'b0 || dc_resp_valid !== 1'b1) begin
            fails++;
            $display("FAIL prio_resp: got ic_rdy=%b dc_v=%b want 0 1", ic_req_ready, dc_resp_valid);
        end
        tick();
        tests++;
        if (ic_req_ready !== 1'b1) begin
            fails++;
            $display("FAIL prio_second: got ic_rdy=%b want 1", ic_req_ready);
        end
        tick();
        ic_req_valid = 1'b0;
        tests++;
        if (mem_req_addr !== 32'h0000_3000 || mem_req_valid !== 1'b1) begin
            fails++;
            $display("FAIL prio_ic_issue: got addr=%h v=%b want 00003000 1",
                     mem_req_addr, mem_req_valid);
        end
        finish_txn(LINE_B);
    endtask
`endif

    task automatic test_stray_resp();
        mem_resp_valid = 1'b1;
        mem_resp_rdata = 128'hBAD;
        tick();
        tests++;
        if (busy !== 1'b0 || ic_resp_valid !== 1'b0 || dc_resp_valid !== 1'b0) begin
            fails++;
            $display("FAIL stray_idle: got busy=%b ic_v=%b dc_v=%b want 0 0 0",
                     busy, ic_resp_valid, dc_resp_valid);
        end
        mem_resp_valid = 1'b0;
        ic_req_valid   = 1'b1;
        ic_req_addr    = 32'h0000_600C;
        mem_req_ready  = 1'b0;
        tick();
        ic_req_valid   = 1'b0;
        mem_resp_valid = 1'b1;
        tick();
        mem_resp_valid = 1'b0;
        tests++;
        if (mem_req_valid !== 1'b1 || mem_req_addr !== 32'h0000_6000 || ic_resp_valid !== 1'b0) begin
            fails++;
            $display("FAIL stray_issue: got v=%b addr=%h resp_v=%b want 1 00006000 0",
                     mem_req_valid, mem_req_addr, ic_resp_valid);
        end
        mem_req_ready = 1'b1;
        tick();
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b1;
        mem_resp_rdata = LINE_A;
        tick();
        mem_resp_valid = 1'b0;
        tests++;
        if (ic_resp_valid !== 1'b1 || ic_resp_rdata !== LINE_A) begin
            fails++;
            $display("FAIL stray_final: got v=%b data=%h want 1 %h",
                     ic_resp_valid, ic_resp_rdata, LINE_A);
        end
        tick();
    endtask

    task automatic test_reset_mid_txn();
        dc_req_valid = 1'b1;
        dc_req_store = 1'b1;
        dc_req_addr  = 32'h0000_7020;
        dc_req_wdata = WD_1;
        mem_req_ready = 1'b1;
        tick();
        dc_req_valid = 1'b0;
        tick();
        mem_req_ready = 1'b0;
        tests++;
        if (busy !== 1'b1 || mem_req_valid !== 1'b0) begin
            fails++;
            $display("FAIL rst_pre_wait: got busy=%b v=%b want 1 0", busy, mem_req_valid);
        end
        rst_n = 1'b0;
        #1;
        tests++;
        if ({busy, mem_req_valid, mem_req_store, ic_req_ready, dc_req_ready, ic_resp_valid,
             dc_resp_valid} !== 7'b0 || mem_req_addr !== '0 || mem_req_wdata !== '0
            || ic_resp_rdata !== '0 || dc_resp_rdata !== '0) begin
            fails++;
            $display("FAIL rst_mid: got busy=%b v=%b st=%b addr=%h wd=%h ic=%h dc=%h want 0",
                     busy, mem_req_valid, mem_req_store, mem_req_addr, mem_req_wdata,
                     ic_resp_rdata, dc_resp_rdata);
        end
        tick();
        rst_n = 1'b1;
        tick();
        ic_req_valid = 1'b1;
        ic_req_addr  = 32'h0000_5008;
        #1;
        tests++;
        if (ic_req_ready !== 1'b1) begin
            fails++;
            $display("FAIL rst_after_accept: got %b want 1", ic_req_ready);
        end
        tick();
        ic_req_valid = 1'b0;
        tests++;
        if (mem_req_addr !== 32'h0000_5000 || mem_req_store !== 1'b0 || mem_req_wdata !== '0) begin
            fails++;
            $display("FAIL rst_after_issue: got addr=%h st=%b wd=%h want 00005000 0 0",
                     mem_req_addr, mem_req_store, mem_req_wdata);
        end
        mem_req_ready = 1'b1;
        tick();
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b1;
        mem_resp_rdata = LINE_B;
        tick();
        mem_resp_valid = 1'b0;
        tests++;
        if (ic_resp_valid !== 1'b1 || ic_resp_rdata !== LINE_B || dc_resp_valid !== 1'b0) begin
            fails++;
            $display("FAIL rst_after_resp: got v=%b data=%h dc_v=%b want 1 %h 0",
                     ic_resp_valid, ic_resp_rdata, dc_resp_valid, LINE_B);
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_ic_read();
        tick();
        test_dc_store_stall();
        tick();
`ifdef MEM_ARBITER_RR_EN
        test_round_robin();
`else
        test_fixed_priority();
`endif
        test_stray_resp();
        test_reset_mid_txn();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
